// File: rtl/bcd_down_pkg.sv
// rtl/bcd_down_pkg.sv - shared state type, digit constants and sanitizer for the BCD down timer
package bcd_down_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BCD_W        = 4;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         PRESCALE_DIV = 10;

  // Out-of-range nibbles saturate to 9 so the stored value is always legal BCD.
  function automatic logic [BCD_W-1:0] sanitize_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - combinational single-digit BCD decrementer with borrow chain
module bcd_digit_dec
  import bcd_down_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_next,
  output logic             borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - multi-digit BCD countdown timer with one-shot or auto-reload expiry
// Optional: define BCD_DOWN_PRESCALE_EN for a mod-10 prescaler (10 enabled cycles per count step).
module bcd_down_timer
  import bcd_down_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  en,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  zero,
  output logic                  load_err
);

  localparam int CW = BCD_W * DIGITS;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   reload_q, reload_d;
  logic [CW-1:0]   count_dec;
  logic [CW-1:0]   load_clean;
  logic            load_bad;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DIGITS:0] borrow;
  logic            step;
  logic            at_one;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_dec u_dec (
      .digit      (count_q[i*BCD_W +: BCD_W]),
      .borrow_in  (borrow[i]),
      .digit_next (count_dec[i*BCD_W +: BCD_W]),
      .borrow_out (borrow[i+1])
    );
  end

  // A borrow out of the top digit means the count was 0; treat it as expiry so a run never wraps to all 9s.
  assign at_one = (count_dec == '0) || borrow[DIGITS];

  always_comb begin
    load_clean = '0;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clean[i*BCD_W +: BCD_W] = sanitize_digit(load_val[i*BCD_W +: BCD_W]);
      if (load_val[i*BCD_W +: BCD_W] > BCD_MAX) begin
        load_bad = 1'b1;
      end
    end
  end

`ifdef BCD_DOWN_PRESCALE_EN
  localparam logic [BCD_W-1:0] PRE_LAST = BCD_W'(PRESCALE_DIV - 1);

  logic [BCD_W-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (state_q == RUN && en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (load || (start && state_q != RUN)) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign step = (state_q == RUN) && en;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_clean;
      reload_d = load_clean;
      err_d    = load_bad;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && count_q != '0) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (step) begin
            if (at_one) begin
              done_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else begin
              count_d = count_dec;
            end
          end
        end
        DONE: begin
          if (start) begin
            count_d = reload_q;
            state_d = (reload_q != '0) ? RUN : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign count    = count_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign zero     = (count_q == '0);
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - vector table, corner sequences and randomized model check for bcd_down_timer
module tb_bcd_down_timer;

  localparam int DIGITS = 2;
  localparam int CW     = 4 * DIGITS;
`ifdef BCD_DOWN_PRESCALE_EN
  localparam int DIV = 10;
`else
  localparam int DIV = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic          start = 1'b0;
  logic          en = 1'b0;
  logic          auto_reload = 1'b0;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          zero;
  logic          load_err;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .zero        (zero),
    .load_err    (load_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst, ld;
    logic [7:0]  lv;
    bit          st, en, ar;
    logic [7:0]  ec;
    bit          eb, ed, ez, ee;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: plain integer value, mode 0=idle 1=running 2=expired.
  int m_cnt = 0, m_rel = 0, m_pre = 0, m_mode = 0;
  bit m_done = 0, m_err = 0;

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic void add(bit rst, bit ld, logic [7:0] lv, bit st, bit e, bit ar,
                              logic [7:0] ec, bit eb, bit ed, bit ez, bit ee);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.en = e; v.ar = ar;
    v.ec = ec; v.eb = eb; v.ed = ed; v.ez = ez; v.ee = ee;
    vecs.push_back(v);
  endfunction

  function automatic void model_step(bit rst, bit ld, logic [CW-1:0] lv, bit st, bit e, bit ar);
    int val, mul, d;
    bit bad;
    m_done = 0;
    if (rst) begin
      m_cnt = 0; m_rel = 0; m_mode = 0; m_err = 0; m_pre = 0;
    end else if (ld) begin
      val = 0; mul = 1; bad = 0;
      for (int i = 0; i < DIGITS; i++) begin
        d = int'(lv[i*4 +: 4]);
        if (d > 9) begin d = 9; bad = 1; end
        val += d * mul;
        mul *= 10;
      end
      m_cnt = val; m_rel = val; m_err = bad; m_mode = 0; m_pre = 0;
    end else if (st && m_mode != 1) begin
      m_pre = 0;
      if (m_mode == 0) begin
        if (m_cnt != 0) m_mode = 1;
      end else begin
        m_cnt  = m_rel;
        m_mode = (m_rel != 0) ? 1 : 0;
      end
    end else if (m_mode == 1 && e) begin
      m_pre++;
      if (m_pre == DIV) begin
        m_pre = 0;
        if (m_cnt == 1) begin
          m_done = 1;
          if (ar) m_cnt = m_rel;
          else begin m_cnt = 0; m_mode = 2; end
        end else begin
          m_cnt--;
        end
      end
    end
  endfunction

  task automatic cycle(input bit rst, input bit ld, input logic [CW-1:0] lv,
                       input bit st, input bit e, input bit ar);
    reset = rst; load = ld; load_val = lv; start = st; en = e; auto_reload = ar;
    @(posedge clock);
    #1;
    model_step(rst, ld, lv, st, e, ar);
  endtask

  task automatic check(input string name, input logic [CW-1:0] ec,
                       input bit eb, input bit ed, input bit ez, input bit ee);
    n_vec++;
    if (count !== ec || busy !== eb || done !== ed || zero !== ez || load_err !== ee) begin
      n_fail++;
      $display("FAIL %s: got count=%h busy=%b done=%b zero=%b load_err=%b, expected count=%h busy=%b done=%b zero=%b load_err=%b",
               name, count, busy, done, zero, load_err, ec, eb, ed, ez, ee);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int first, second;
    bit busy_ok;
    logic [CW-1:0] lv;

    // Countdown 12 -> 00, single done, hold in DONE, restart from reload
    add(1,0,8'h00,0,0,0, 8'h00,0,0,1,0);
    add(0,1,8'h12,0,0,0, 8'h12,0,0,0,0);
    add(0,0,8'h00,1,0,0, 8'h12,1,0,0,0);
    for (int v = 11; v >= 1; v--) add(0,0,8'h00,0,1,0, to_bcd(v),1,0,0,0);
    add(0,0,8'h00,0,1,0, 8'h00,0,1,1,0);
    add(0,0,8'h00,0,1,0, 8'h00,0,0,1,0);
    add(0,0,8'h00,1,0,0, 8'h12,1,0,0,0);
    add(0,0,8'h00,0,0,0, 8'h12,1,0,0,0);
    // Auto-reload 03: load aborts the run without done, then period of 3
    add(0,1,8'h03,0,0,1, 8'h03,0,0,0,0);
    add(0,0,8'h00,1,0,1, 8'h03,1,0,0,0);
    for (int k = 0; k < 10; k++)
      add(0,0,8'h00,0,1,1, (k%3==0) ? 8'h02 : (k%3==1) ? 8'h01 : 8'h03, 1, (k%3==2), 0, 0);
    // Tens borrow with en toggling, start ignored while running
    add(0,1,8'h20,0,0,0, 8'h20,0,0,0,0);
    add(0,0,8'h00,1,0,0, 8'h20,1,0,0,0);
    add(0,0,8'h00,0,1,0, 8'h19,1,0,0,0);
    add(0,0,8'h00,0,0,0, 8'h19,1,0,0,0);
    add(0,0,8'h00,0,1,0, 8'h18,1,0,0,0);
    add(0,0,8'h00,0,0,0, 8'h18,1,0,0,0);
    add(0,0,8'h00,1,1,0, 8'h17,1,0,0,0);
    // Sanitizing and load_err lifetime, start on zero
    add(0,1,8'h1A,0,0,0, 8'h19,0,0,0,1);
    add(0,1,8'h05,0,0,0, 8'h05,0,0,0,0);
    add(0,1,8'hF9,0,0,0, 8'h99,0,0,0,1);
    add(0,0,8'h00,1,0,0, 8'h99,1,0,0,1);
    add(0,1,8'h00,0,0,0, 8'h00,0,0,1,0);
    add(0,0,8'h00,1,1,0, 8'h00,0,0,1,0);
    // load+start mid-run, then reset mid-run
    add(0,1,8'h05,0,0,0, 8'h05,0,0,0,0);
    add(0,0,8'h00,1,0,0, 8'h05,1,0,0,0);
    add(0,0,8'h00,0,1,0, 8'h04,1,0,0,0);
    add(0,0,8'h00,0,1,0, 8'h03,1,0,0,0);
    add(0,1,8'h07,1,1,0, 8'h07,0,0,0,0);
    add(0,0,8'h00,1,0,0, 8'h07,1,0,0,0);
    add(0,0,8'h00,0,1,0, 8'h06,1,0,0,0);
    add(1,0,8'h00,1,1,0, 8'h00,0,0,1,0);

    cycle(1, 0, '0, 0, 0, 0);
`ifndef BCD_DOWN_PRESCALE_EN
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].en, vecs[i].ar);
      check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].eb, vecs[i].ed, vecs[i].ez, vecs[i].ee);
    end
`else
    // Prescaled: 02 -> 01 after 10 enabled cycles, 00 with done after 20
    cycle(0, 1, 8'h02, 0, 0, 0);
    cycle(0, 0, '0, 1, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      cycle(0, 0, '0, 0, 1, 0);
      if (c == 9)  check("pre_c9",  8'h02, 1, 0, 0, 0);
      if (c == 10) check("pre_c10", 8'h01, 1, 0, 0, 0);
      if (c == 19) check("pre_c19", 8'h01, 1, 0, 0, 0);
      if (c == 20) check("pre_c20", 8'h00, 0, 1, 1, 0);
    end
`endif

    // Auto-reload period measured in enabled cycles
    cycle(1, 0, '0, 0, 0, 0);
    cycle(0, 1, 8'h05, 0, 0, 1);
    cycle(0, 0, '0, 1, 0, 1);
    first = -1; second = -1; busy_ok = 1;
    for (int c = 1; c <= 400 && second < 0; c++) begin
      cycle(0, 0, '0, 0, 1, 1);
      if (!busy) busy_ok = 0;
      if (done) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    check_val("first_expiry", first, 5 * DIV);
    check_val("reload_period", (second < 0) ? -1 : second - first, 5 * DIV);
    check_val("reload_busy", int'(busy_ok), 1);

    // Randomized traffic against the reference model
    cycle(1, 0, '0, 0, 0, 0);
    check("rand_reset", to_bcd(m_cnt), m_mode == 1, m_done, m_cnt == 0, m_err);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(1, 0) == 0)
        lv = {4'($urandom_range(2, 0)), 4'($urandom_range(9, 0))};
      else
        lv = CW'($urandom);
      cycle($urandom_range(99, 0) == 0, $urandom_range(19, 0) == 0, lv,
            $urandom_range(7, 0) == 0, $urandom_range(3, 0) != 0,
            $urandom_range(3, 0) == 0);
      check($sformatf("rand%0d", n), to_bcd(m_cnt), m_mode == 1, m_done, m_cnt == 0, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit BCD countdown timer. It is the down-counting, load-and-expire counterpart of the team's free-running decade up-counter.
- Software or an FSM loads a BCD value, starts it, and the block counts down to zero. At zero it raises a one-cycle done pulse, then either stops or auto-reloads.
- Sits beside the decade counters in the COUNTER library. Its output feeds 7-segment/BCD display logic directly.

Parameters:
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture load_val into count and into the reload register.
- load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0].
- start  in  1  arm or re-arm countdown.
- en  in  1  count gate; low pauses the countdown in RUN.
- auto_reload  in  1  on expiry, reload and keep running instead of stopping.
- count  out  4*DIGITS  current BCD value (registered).
- busy  out  1  state == RUN.
- done  out  1  one-cycle pulse on expiry.
- zero  out  1  count == 0 (combinational from the count register).
- load_err  out  1  last load contained a digit greater than 9.

Behaviour:
- Reset (sync): count=0, reload register=0, state=IDLE, done=0, load_err=0. busy=0 and zero=1 follow from these.
- State IDLE:
  - load → count=reload=load_val (sanitized), stay IDLE.
  - start with count!=0 → RUN. start with count==0 → stays IDLE.
- State RUN: on a cycle with en=1, count decrements by 1 in BCD.
  - Each digit goes 0→9 with a borrow into the next digit. Borrow ripples across all digits in the same cycle.
  - en=0 → hold.
- Expiry: the decrement from value 1.
  - auto_reload=0: count becomes 0, done=1 for that cycle, state → DONE.
  - auto_reload=1: count becomes the reload value, done=1, state stays RUN.
  - Period is therefore reload-value enabled cycles.
- State DONE: count holds 0. start → count=reload, state RUN (if reload!=0; else IDLE). load → IDLE with new value.
- Latency:
  - load_val appears on count the cycle after load.
  - busy rises the cycle after start.
  - The first decrement occurs on the first en=1 cycle after busy rises.
  - done is registered and coincides with the count update it reports.
- Priority: reset > load > start > decrement. load during RUN aborts the run: state → IDLE, no done pulse. start while RUN is ignored.
- Sanitizing: any load_val digit >9 is stored as 9. load_err=1 from the next cycle until the next fully valid load (or reset).
- Reset mid-run: immediate return to reset values next cycle; no done pulse.
- done never asserts in IDLE, on a load, or on reset.

Optional Feature:
- Macro BCD_DOWN_PRESCALE_EN.
- Defined: an internal mod-10 prescaler advances on en=1 cycles in RUN. count decrements only when the prescaler wraps 9→0, giving 10 enabled cycles per count step.
  - Prescaler clears to 0 on reset, load, start, and expiry.
  - Holds when en=0.
- Undefined: no prescaler; decrement on every en=1 cycle in RUN.

Decomposition:
- Package bcd_down_pkg:
  - state enum: IDLE, RUN, DONE.
  - BCD_W=4.
  - BCD_MAX=4'd9.
  - PRESCALE_DIV=10.
- Sub-module bcd_digit_dec: combinational single-digit decrementer.
  - Inputs: digit, borrow_in.
  - Outputs: digit_next, borrow_out.
  - Instantiated DIGITS times in a generate chain.
- Top level holds the FSM, registers, sanitizer and the optional prescaler.

Test Plan:
- reset, load 8'h12, start, en=1 continuously → count 12,11,10,09,…,01,00. done pulses exactly once, with count=00. busy falls the same cycle. State DONE, count holds 00.
- load 8'h03, auto_reload=1, start, en=1 for 10 cycles → count 03,02,01,03,02,01,… with done on each 01→03 step. busy stays 1.
- load 8'h20, start, en toggled 1/0 each cycle → count 20,19,18 advancing only on en=1 cycles. The tens borrow 20→19 happens in one cycle.
- load 8'h1A → count=8'h19, load_err=1. Next load 8'h05 → load_err=0. start with count=00 → busy stays 0.
- load 8'h05, start, after 2 decrements assert load 8'h07 together with start → count=07, state IDLE, no done. Then reset mid-run → count=00, busy=0, done=0 next cycle.
- With BCD_DOWN_PRESCALE_EN: load 8'h02, start, en=1 → count 02→01 after 10 enabled cycles, 01→00 and done after 20.
